// File: rtl/scope_udp_packet_mc_if.sv
// scope_udp_packet_mc_if
//   AXI-Stream byte channel from the scope packetiser toward the UDP/IP TX
//   stack.
//   axis_data  [7:0]  packet byte
//   axis_user  [15:0] total packet length in bytes (header + payload)
//   axis_valid        byte valid
//   axis_last         final payload byte of the packet
//   axis_ready        downstream accepts the byte
//   master: packetiser side, slave: stack side.
interface scope_udp_packet_mc_if;
  logic [7:0]  axis_data;
  logic [15:0] axis_user;
  logic        axis_valid;
  logic        axis_last;
  logic        axis_ready;

  modport master (
    output axis_data,
    output axis_user,
    output axis_valid,
    output axis_last,
    input  axis_ready
  );

  modport slave (
    input  axis_data,
    input  axis_user,
    input  axis_valid,
    input  axis_last,
    output axis_ready
  );
endinterface

// File: rtl/scope_udp_packet_mc.sv
// scope_udp_packet_mc
//   Multi-channel scope packetiser. Each of P_CH 8-bit sample streams is
//   buffered in its own FIFO. When a channel holds a full payload it is
//   granted round-robin and framed as one UDP application packet
//   (header, then P_PAYLOAD samples) on a single AXI-Stream master.
//
//   Header: msg id, dest id, lifetime, type, channel,
//           [seq hi, seq lo,] payload len hi, payload len lo
//
//   Optional feature macro: SCOPE_PKT_SEQ_EN
//     defined   - per-channel 16-bit sequence counter carried in the header
//                 after the channel byte (9-byte header).
//     undefined - 7-byte header, no counters.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_user_data   8*P_CH sample bytes, channel c at [8c+7:8c]
//   i_user_valid  per-channel sample valid
//   o_user_ready  per-channel FIFO not full (0 while in reset)
//   axis          AXI-Stream master (data/user/valid/last/ready)
//   o_busy        packet in progress, from grant to last byte accepted
module scope_udp_packet_mc #(
  parameter int unsigned P_CH      = 4,
  parameter int unsigned P_PAYLOAD = 1008,
  parameter int unsigned P_DEPTH   = 2048,
  parameter int unsigned P_MSG_ID  = 123,
  parameter int unsigned P_DEST_ID = 0,
  parameter int unsigned P_LIFE    = 1,
  parameter int unsigned P_TYPE    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [8*P_CH-1:0]     i_user_data,
  input  logic [P_CH-1:0]       i_user_valid,
  output logic [P_CH-1:0]       o_user_ready,
  scope_udp_packet_mc_if.master axis,
  output logic                  o_busy
);

`ifdef SCOPE_PKT_SEQ_EN
  localparam int unsigned P_HEAD = 9;
`else
  localparam int unsigned P_HEAD = 7;
`endif
  localparam int unsigned P_TOTAL = P_HEAD + P_PAYLOAD;
  localparam int unsigned AW      = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int unsigned CW      = $clog2(P_DEPTH + 1);
  localparam int unsigned CHW     = (P_CH > 1) ? $clog2(P_CH) : 1;
  localparam int unsigned IW      = $clog2(P_TOTAL);

  localparam logic [15:0]    LEN           = 16'(P_PAYLOAD);
  localparam logic [IW-1:0]  IDX_HEAD_LAST = IW'(P_HEAD - 1);
  localparam logic [IW-1:0]  IDX_LAST      = IW'(P_TOTAL - 1);
  localparam logic [AW-1:0]  PTR_MAX       = AW'(P_DEPTH - 1);
  localparam logic [CW-1:0]  FILL_FULL     = CW'(P_DEPTH);
  localparam logic [CW-1:0]  FILL_ELIG     = CW'(P_PAYLOAD);
  localparam logic [CHW-1:0] CH_LAST       = CHW'(P_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_HEAD,
    S_DATA
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------
  logic [7:0]    mem    [P_CH][P_DEPTH];
  logic [AW-1:0] wr_ptr [P_CH];
  logic [AW-1:0] rd_ptr [P_CH];
  logic [CW-1:0] fill   [P_CH];
  logic [P_CH-1:0] wr_en;
  logic [P_CH-1:0] rd_en;
  logic [P_CH-1:0] elig;
  logic            rst_done;

  // Packet control
  logic           start;
  logic           accept;
  logic           pop;
  logic           pkt_done;
  logic [CHW-1:0] gnt_q;
  logic [CHW-1:0] gnt_nxt;
  logic [CHW-1:0] rr_idx;
  logic           rr_found;
  logic [CHW-1:0] last_srv_q;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  idx_nxt;
  logic [3:0]     hdr_sel;
  logic [7:0]     hdr_byte;
  logic [7:0]     rd_byte;
  logic [7:0]     data_q;
  logic           valid_q;
  logic           last_q;

`ifdef SCOPE_PKT_SEQ_EN
  logic [P_CH-1:0][15:0] seq_q;
`endif

  // Ready is held low until the first clock after reset release so no
  // write can land while the FIFO state is still being cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  always_comb begin
    o_user_ready = '0;
    elig         = '0;
    wr_en        = '0;
    rd_en        = '0;
    for (int unsigned c = 0; c < P_CH; c++) begin
      o_user_ready[c] = rst_done && (fill[c] != FILL_FULL);
      elig[c]         = (fill[c] >= FILL_ELIG);
      wr_en[c]        = i_user_valid[c] && o_user_ready[c];
      rd_en[c]        = pop && (gnt_q == CHW'(c));
    end
  end

  // Sample storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    for (int unsigned c = 0; c < P_CH; c++) begin
      if (wr_en[c]) begin
        mem[c][wr_ptr[c]] <= i_user_data[8*c +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned c = 0; c < P_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        fill[c]   <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < P_CH; c++) begin
        if (wr_en[c]) begin
          wr_ptr[c] <= (wr_ptr[c] == PTR_MAX) ? '0 : wr_ptr[c] + 1'b1;
        end
        if (rd_en[c]) begin
          rd_ptr[c] <= (rd_ptr[c] == PTR_MAX) ? '0 : rd_ptr[c] + 1'b1;
        end
        case ({wr_en[c], rd_en[c]})
          2'b10:   fill[c] <= fill[c] + 1'b1;
          2'b01:   fill[c] <= fill[c] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Head-of-FIFO byte of the granted channel. It is captured into the
  // output register on the same edge that pops it, so the output register
  // doubles as the prefetch stage and payload bytes stream without gaps.
  assign rd_byte = mem[gnt_q][rd_ptr[gnt_q]];

  // ---------------------------------------------------------------------
  // Round-robin arbiter: first eligible channel after the last served one
  // ---------------------------------------------------------------------
  always_comb begin
    gnt_nxt  = last_srv_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 1; k <= P_CH; k++) begin
      rr_idx = CHW'((32'(last_srv_q) + k) % P_CH);
      if (!rr_found && elig[rr_idx]) begin
        gnt_nxt  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // idx_q is the index of the byte currently presented; every accepted
  // byte except the final one loads its successor.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    accept   = 1'b0;
    pop      = 1'b0;
    pkt_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        start   = 1'b1;
        state_d = S_HEAD;
      end
      S_HEAD: begin
        accept = axis.axis_ready;
        pop    = accept && (idx_q == IDX_HEAD_LAST);
        if (pop) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        accept   = axis.axis_ready;
        pkt_done = accept && (idx_q == IDX_LAST);
        pop      = accept && !pkt_done;
        if (pkt_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign idx_nxt = idx_q + 1'b1;
  assign hdr_sel = 4'(idx_nxt);

  always_comb begin
    hdr_byte = '0;
    case (hdr_sel)
      4'd0:    hdr_byte = 8'(P_MSG_ID);
      4'd1:    hdr_byte = 8'(P_DEST_ID);
      4'd2:    hdr_byte = 8'(P_LIFE);
      4'd3:    hdr_byte = 8'(P_TYPE);
      4'd4:    hdr_byte = 8'(gnt_q);
`ifdef SCOPE_PKT_SEQ_EN
      4'd5:    hdr_byte = seq_q[gnt_q][15:8];
      4'd6:    hdr_byte = seq_q[gnt_q][7:0];
      4'd7:    hdr_byte = LEN[15:8];
      4'd8:    hdr_byte = LEN[7:0];
`else
      4'd5:    hdr_byte = LEN[15:8];
      4'd6:    hdr_byte = LEN[7:0];
`endif
      default: hdr_byte = '0;
    endcase
  end

  // Output register: only changes on start or on an accepted byte, so
  // data and last hold while ready is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      gnt_q      <= '0;
      last_srv_q <= CH_LAST;
    end else if (start) begin
      gnt_q   <= gnt_nxt;
      data_q  <= 8'(P_MSG_ID);
      valid_q <= 1'b1;
      last_q  <= 1'b0;
      idx_q   <= '0;
    end else if (pkt_done) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      last_srv_q <= gnt_q;
    end else if (accept) begin
      idx_q  <= idx_nxt;
      data_q <= pop ? rd_byte : hdr_byte;
      last_q <= (idx_nxt == IDX_LAST);
    end
  end

`ifdef SCOPE_PKT_SEQ_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seq_q <= '0;
    end else if (pkt_done) begin
      seq_q[gnt_q] <= seq_q[gnt_q] + 16'd1;
    end
  end
`endif

  assign axis.axis_data  = data_q;
  assign axis.axis_valid = valid_q;
  assign axis.axis_last  = last_q;
  assign axis.axis_user  = 16'(P_TOTAL);
  assign o_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_scope_udp_packet_mc.sv
// tb_scope_udp_packet_mc
//   Scoreboard bench for scope_udp_packet_mc with P_CH=2, P_PAYLOAD=16,
//   P_DEPTH=32. Stimulus pushes expected packet bytes into a queue; the
//   monitor pops and compares on every accepted AXIS byte.
module tb_scope_udp_packet_mc;
  localparam int unsigned CH  = 2;
  localparam int unsigned PAY = 16;
  localparam int unsigned DEP = 32;
`ifdef SCOPE_PKT_SEQ_EN
  localparam int unsigned HEAD = 9;
`else
  localparam int unsigned HEAD = 7;
`endif
  localparam int unsigned TOT = HEAD + PAY;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [8*CH-1:0] user_data = '0;
  logic [CH-1:0]   user_valid = '0;
  logic [CH-1:0]   user_ready;
  logic            busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  exp_t sb [$];
  exp_t e;
  logic       hold_pend;
  logic       gap_pend;
  logic [7:0] hold_data;
  logic       hold_last;
  int unsigned cnt;

`ifdef SCOPE_PKT_SEQ_EN
  logic [15:0] exp_seq [CH];
`endif

  scope_udp_packet_mc_if axis_if ();

  scope_udp_packet_mc #(
    .P_CH      (CH),
    .P_PAYLOAD (PAY),
    .P_DEPTH   (DEP)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_user_data  (user_data),
    .i_user_valid (user_valid),
    .o_user_ready (user_ready),
    .axis         (axis_if),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic push_pkt(input int unsigned ch, input logic [7:0] p0);
    logic [7:0] hdr [HEAD];
    exp_t t;
    hdr[0] = 8'd123;
    hdr[1] = 8'd0;
    hdr[2] = 8'd1;
    hdr[3] = 8'd0;
    hdr[4] = 8'(ch);
`ifdef SCOPE_PKT_SEQ_EN
    hdr[5] = exp_seq[ch][15:8];
    hdr[6] = exp_seq[ch][7:0];
    hdr[7] = 8'h00;
    hdr[8] = 8'h10;
    exp_seq[ch] = exp_seq[ch] + 16'd1;
`else
    hdr[5] = 8'h00;
    hdr[6] = 8'h10;
`endif
    for (int unsigned i = 0; i < HEAD; i++) begin
      t.d = hdr[i];
      t.l = 1'b0;
      sb.push_back(t);
    end
    for (int unsigned i = 0; i < PAY; i++) begin
      t.d = p0 + 8'(i);
      t.l = (i == PAY - 1);
      sb.push_back(t);
    end
  endtask

  task automatic wr(input int unsigned ch, input logic [7:0] v);
    user_data[8*ch +: 8] = v;
    user_valid[ch] = 1'b1;
    @(posedge clk); #1;
    user_valid[ch] = 1'b0;
  endtask

  task automatic wr2(input logic [7:0] v0, input logic [7:0] v1);
    user_data  = {v1, v0};
    user_valid = 2'b11;
    @(posedge clk); #1;
    user_valid = '0;
  endtask

  task automatic finish_reset();
    sb.delete();
`ifdef SCOPE_PKT_SEQ_EN
    foreach (exp_seq[i]) exp_seq[i] = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_ready", 32'(user_ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", 32'(user_ready), 3);
  endtask

  task automatic do_reset();
    axis_if.axis_ready = 1'b0;
    user_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(axis_if.axis_valid), 0);
    check("rst_last", 32'(axis_if.axis_last), 0);
    check("rst_data", 32'(axis_if.axis_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(user_ready), 0);
    finish_reset();
  endtask

  task automatic drain(input bit toggle, input string nm);
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || axis_if.axis_valid) && n < 3000) begin
      if (toggle) axis_if.axis_ready = ~axis_if.axis_ready;
      @(posedge clk); #1;
      n++;
    end
    axis_if.axis_ready = 1'b1;
    check({nm, "_drained"}, 32'(sb.size()), 0);
    check({nm, "_busy_idle"}, 32'(busy), 0);
  endtask

  // Monitor / scoreboard
  initial begin
    hold_pend = 1'b0;
    gap_pend  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
        gap_pend  = 1'b0;
      end else begin
        if (gap_pend) check("gap_valid_low", 32'(axis_if.axis_valid), 0);
        if (hold_pend) begin
          check("hold_valid", 32'(axis_if.axis_valid), 1);
          check("hold_data", 32'(axis_if.axis_data), 32'(hold_data));
          check("hold_last", 32'(axis_if.axis_last), 32'(hold_last));
        end
        hold_pend = 1'b0;
        gap_pend  = 1'b0;
        if (axis_if.axis_valid && !axis_if.axis_ready) begin
          hold_pend = 1'b1;
          hold_data = axis_if.axis_data;
          hold_last = axis_if.axis_last;
        end
        if (axis_if.axis_valid && axis_if.axis_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no output",
                     axis_if.axis_data);
          end else begin
            e = sb.pop_front();
            check("byte", 32'(axis_if.axis_data), 32'(e.d));
            check("last", 32'(axis_if.axis_last), 32'(e.l));
            check("user", 32'(axis_if.axis_user), TOT);
            gap_pend = axis_if.axis_last;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    axis_if.axis_ready = 1'b0;

    // Single packet, ready high
    do_reset();
    axis_if.axis_ready = 1'b1;
    push_pkt(0, 8'h00);
    for (int unsigned i = 0; i < PAY; i++) wr(0, 8'(i));
    @(posedge clk); #1;
    check("lat_arb_valid", 32'(axis_if.axis_valid), 0);
    check("lat_arb_busy", 32'(busy), 1);
    @(posedge clk); #1;
    check("lat_first_valid", 32'(axis_if.axis_valid), 1);
    cnt = 0;
    while (axis_if.axis_valid && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("run_len", cnt, TOT);
    drain(1'b0, "single");

    // Back-pressure, ready toggling
    push_pkt(0, 8'h20);
    for (int unsigned i = 0; i < PAY; i++) wr(0, 8'h20 + 8'(i));
    drain(1'b1, "backpressure");

    // Round-robin: both eligible together after reset
    do_reset();
    axis_if.axis_ready = 1'b1;
    push_pkt(0, 8'h40);
    push_pkt(1, 8'h80);
    for (int unsigned i = 0; i < PAY; i++) wr2(8'h40 + 8'(i), 8'h80 + 8'(i));
    drain(1'b0, "rr_first");
    push_pkt(0, 8'hA0);
    push_pkt(1, 8'hC0);
    for (int unsigned i = 0; i < PAY; i++) wr2(8'hA0 + 8'(i), 8'hC0 + 8'(i));
    drain(1'b0, "rr_refill");

    // Full FIFO on ch1 with downstream stalled
    do_reset();
    push_pkt(1, 8'd1);
    push_pkt(1, 8'd17);
    for (int unsigned i = 1; i <= 40; i++) begin
      check("full_ready_ch1", 32'(user_ready[1]), (i <= DEP) ? 1 : 0);
      wr(1, 8'(i));
    end
    check("full_ready_ch0", 32'(user_ready[0]), 1);
    axis_if.axis_ready = 1'b1;
    drain(1'b0, "full");

    // Reset during payload byte 5
    do_reset();
    axis_if.axis_ready = 1'b1;
    push_pkt(0, 8'h50);
    for (int unsigned i = 0; i < PAY; i++) wr(0, 8'h50 + 8'(i));
    repeat (2 + HEAD + 4) @(posedge clk);
    #1;
    check("pre_rst_byte", 32'(axis_if.axis_data), 32'h54);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(axis_if.axis_valid), 0);
    check("midrst_ready", 32'(user_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    finish_reset();
    axis_if.axis_ready = 1'b1;
    for (int unsigned i = 0; i < PAY - 1; i++) wr(0, 8'h60 + 8'(i));
    repeat (20) @(posedge clk);
    #1;
    check("no_early_valid", 32'(axis_if.axis_valid), 0);
    push_pkt(0, 8'h60);
    wr(0, 8'h6F);
    drain(1'b0, "after_rst");

`ifdef SCOPE_PKT_SEQ_EN
    // Sequence numbering and wrap
    do_reset();
    axis_if.axis_ready = 1'b1;
    for (int unsigned p = 0; p < 3; p++) begin
      push_pkt(0, 8'(16 * p));
      for (int unsigned i = 0; i < PAY; i++) wr(0, 8'(16 * p + i));
      drain(1'b0, "seq");
    end
    force dut.seq_q[0] = 16'hFFFF;
    @(posedge clk); #1;
    release dut.seq_q[0];
    exp_seq[0] = 16'hFFFF;
    for (int unsigned p = 0; p < 2; p++) begin
      push_pkt(0, 8'h30 + 8'(16 * p));
      for (int unsigned i = 0; i < PAY; i++) wr(0, 8'h30 + 8'(16 * p + i));
      drain(1'b0, "seq_wrap");
    end
`endif

    check("final_queue_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
